button_debouncer: RTL

Front-end conditioning stage for a push-button. It synchronises the raw asynchronous pin into the `i_clk` domain and filters contact bounce with a four-state debounce FSM. It emits clean single-cycle press, release and long-press pulses plus a debounced level. `o_press` drives the `i_press` input of the LED on-timer stage directly downstream.

---
 rtl/button_debouncer.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/button_debouncer.sv
// Push-button front end: synchronises the raw pin, rejects contact bounce with a
// four-state FSM and produces registered press / release / long-press pulses plus
// a debounced pressed level.
module button_debouncer #(
   parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
   parameter int unsigned LONG_CYCLES     = 50_000_000,
   parameter bit          ACTIVE_LOW      = 1'b1
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_button,
   output logic o_press,
   output logic o_release,
   output logic o_long,
   output logic o_level
);

   localparam int unsigned DcntW = $clog2(DEBOUNCE_CYCLES);
   localparam int unsigned LcntW = $clog2(LONG_CYCLES);

   // Terminal counts; counters stop here, so they never wrap.
   localparam logic [DcntW-1:0] DcntLast = DcntW'(DEBOUNCE_CYCLES - 1);
   localparam logic [LcntW-1:0] LcntLast = LcntW'(LONG_CYCLES - 1);

   typedef enum logic [1:0] {
      StIdle,
      StPressing,
      StHeld,
      StReleasing
   } state_e;

   state_e             state_q;
   logic               sync1_q;
   logic               sync2_q;
   logic [DcntW-1:0]   dcnt_q;
   logic [LcntW-1:0]   lcnt_q;
   logic               long_done_q;
   logic               press_q;
   logic               release_q;
   logic               long_q;
   logic               level_q;

   logic               btn_n;
   logic               s_btn;

   // Normalised so that 1 always means "pressed", whatever the board polarity.
   assign btn_n = i_button ^ ACTIVE_LOW;
   assign s_btn = sync2_q;

   // Two-flop synchroniser bringing the asynchronous pin into the i_clk domain.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
      end else begin
         sync1_q <= btn_n;
         sync2_q <= sync1_q;
      end
   end

   // Debounce FSM with counters and registered single-cycle output pulses.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q     <= StIdle;
         dcnt_q      <= '0;
         lcnt_q      <= '0;
         long_done_q <= 1'b0;
         press_q     <= 1'b0;
         release_q   <= 1'b0;
         long_q      <= 1'b0;
         level_q     <= 1'b0;
      end else begin
         // Pulses default low so each lasts exactly one cycle.
         press_q   <= 1'b0;
         release_q <= 1'b0;
         long_q    <= 1'b0;

         unique case (state_q)
            StIdle: begin
               if (s_btn) begin
                  state_q <= StPressing;
                  dcnt_q  <= '0;
               end
            end

            StPressing: begin
               if (!s_btn) begin
                  // Bounce: drop back silently and requalify on the next edge.
                  state_q <= StIdle;
               end else if (dcnt_q == DcntLast) begin
                  state_q     <= StHeld;
                  press_q     <= 1'b1;
                  level_q     <= 1'b1;
                  lcnt_q      <= '0;
                  long_done_q <= 1'b0;
               end else begin
                  dcnt_q <= dcnt_q + 1'b1;
               end
            end

            StHeld: begin
               if (!s_btn) begin
                  // Release takes priority over a coincident long terminal count;
                  // lcnt is frozen so a bounce back resumes where it left off.
                  state_q <= StReleasing;
                  dcnt_q  <= '0;
               end else if (!long_done_q) begin
                  if (lcnt_q == LcntLast) begin
                     long_q      <= 1'b1;
                     long_done_q <= 1'b1;
                  end else begin
                     lcnt_q <= lcnt_q + 1'b1;
                  end
               end
            end

            StReleasing: begin
               if (s_btn) begin
                  // Release bounce: still the same press, no new o_press.
                  state_q <= StHeld;
               end else if (dcnt_q == DcntLast) begin
                  state_q   <= StIdle;
                  release_q <= 1'b1;
                  level_q   <= 1'b0;
               end else begin
                  dcnt_q <= dcnt_q + 1'b1;
               end
            end

            default: begin
               state_q <= StIdle;
            end
         endcase
      end
   end

   assign o_press   = press_q;
   assign o_release = release_q;
   assign o_long    = long_q;
   assign o_level   = level_q;

endmodule
